max7219_rx_model: RTL and testbench
===================================

# max7219_rx_model

Synthesizable responder for the MAX7219 3-wire serial interface: the device-side end of the link driven by `max7219_if`. It samples LOAD/DIN/CLK with the system clock, shifts frames, latches them on LOAD rising edges and decodes them into the MAX7219 register map (digits, decode mode, intensity, scan limit, shutdown, display test). It sits on the `o_max7219_*` outputs in the MAX7219 benches so `max7219_cmd_decod` scenarios can be checked at register level instead of by waveform inspection.

## Interface
- `G_SYNC`, 1, 1 inserts a 2-FF synchronizer on each serial input (+2 cycles latency); 0 means inputs are registered once only.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_max7219_load`  in  1  LOAD/CS line.
- `i_max7219_data`  in  1  DIN line.
- `i_max7219_clk`  in  1  serial clock line.
- `o_max7219_dout`  out  1  DOUT (cascade output), MSB of the shift register.
- `o_frame_valid`  out  1  one-cycle pulse: a frame with ≥16 bits was latched.
- `o_frame_err`  out  1  one-cycle pulse: LOAD rose after fewer than 16 bits.
- `o_frame_data`  out  16  last latched 16-bit word, valid or not.
- `o_frame_cnt`  out  16  count of valid frames, wraps 0xFFFF→0.
- `o_decode_mode`  out  8  register 0x9.
- `o_intensity`  out  4  register 0xA bits [3:0].
- `o_scan_limit`  out  3  register 0xB bits [2:0].
- `o_shutdown_n`  out  1  register 0xC bit 0 (0 = shutdown).
- `o_display_test`  out  1  register 0xF bit 0.
- `i_rd_addr`  in  3  digit index 0..7 for readback.
- `o_rd_digit`  out  8  digit register (address i_rd_addr+1), registered.

## Operation
- Input path: optional sync stages (G_SYNC), then sample stage s1 and previous-sample stage s2 for CLK and LOAD; DIN taken from s1. Every stage resets to 1, so a line already high at reset release never produces a false rising edge.
- CLK rise (s1=1, s2=0): sr <= {sr[14:0], din_s1}; bit count `cnt` (5 bit) increments, saturating at 31. Shifting happens whatever the LOAD level is.
- CLK fall (s1=0, s2=1): `o_max7219_dout` <= sr[15].
- LOAD rise: latch word W = sr after any shift in the same cycle. If both edges are detected together, the shift is applied first and W includes the new bit. `o_frame_data` <= W; cnt <= 0.
  - cnt (including any same-cycle shift) ≥ 16: `o_frame_valid` pulse, `o_frame_cnt`+1, register write with addr = W[11:8] and value = W[7:0]. W[15:12] are ignored.
  - cnt < 16: `o_frame_err` pulse; no register write; frame counter unchanged.
- Register map: 0x0 no-op; 0x1–0x8 digit0–7; 0x9 decode (8 b); 0xA intensity [3:0]; 0xB scan limit [2:0]; 0xC shutdown [0]; 0xD/0xE ignored; 0xF display test [0]. Unused value bits are discarded.
- Readback: `o_rd_digit` <= digit[i_rd_addr] every cycle. A write and a read of the same digit in the same cycle returns the old value; the new value appears one cycle later.

## Timing
- Reset values: all registers 0 (device in shutdown: `o_shutdown_n`=0), `o_frame_*` 0, `o_frame_cnt` 0, `o_max7219_dout` 0, sr 0, cnt 0, `o_rd_digit` 0.
- Latency, G_SYNC=0: the first clk edge that samples LOAD high loads s1. At the next edge `o_frame_valid`/`o_frame_err`, `o_frame_data` and the decoded register update together. G_SYNC=1 adds 2 cycles.
- Shift latency follows the same rule: a DIN bit is captured from the same sample as the CLK high it travels with.
- Minimum serial clock high/low time: 1 + 2·G_SYNC system cycles. Pulses shorter than this may be missed; the bench must keep them longer.
- Reset asserted mid-frame: the partial frame is discarded and all state returns to reset values on that edge. The first LOAD rise after reset is an error unless ≥16 bits were clocked after reset.
- Pulse outputs last exactly 1 cycle. Back-to-back LOAD rises at the minimum spacing are each reported.

## Test plan
- After reset, hold lines low, 20 cycles → all outputs 0, `o_shutdown_n`=0, no pulses.
- Shift 0x0C01 MSB-first, then LOAD rise → `o_frame_valid` 1 cycle, `o_frame_data`=0x0C01, `o_shutdown_n`=1, `o_frame_cnt`=1.
- Frames 0x0A3F, 0x0B07, 0x0355 → `o_intensity`=0xF, `o_scan_limit`=7; with `i_rd_addr`=2, `o_rd_digit`=0x55 one cycle after the write.
- 10 bits, then LOAD rise → `o_frame_err` pulse, registers unchanged, `o_frame_cnt` unchanged. A following full frame 0x0F01 → `o_display_test`=1.
- 32 bits 0x01AA_0102, then LOAD rise → valid frame, `o_frame_data`=0x0102, digit0=0x02; `o_max7219_dout` reproduces 0x01AA delayed by 16 CLK cycles.
- `rst` pulsed after 8 bits, then 16 bits 0x0901 and LOAD → valid frame, `o_decode_mode`=0x01. Repeat the run with G_SYNC=0 and G_SYNC=1; `o_frame_valid` must be 2 cycles later with G_SYNC=1.

Source files
------------

// File: rtl/max7219_rx_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// max7219_rx_model : MAX7219 serial responder, decodes frames into its register map
// Rev 1.0
// ============================================================================
module max7219_rx_model #(
   parameter int G_SYNC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_max7219_load,
   input  logic        i_max7219_data,
   input  logic        i_max7219_clk,
   output logic        o_max7219_dout,
   output logic        o_frame_valid,
   output logic        o_frame_err,
   output logic [15:0] o_frame_data,
   output logic [15:0] o_frame_cnt,
   output logic [7:0]  o_decode_mode,
   output logic [3:0]  o_intensity,
   output logic [2:0]  o_scan_limit,
   output logic        o_shutdown_n,
   output logic        o_display_test,
   input  logic [2:0]  i_rd_addr,
   output logic [7:0]  o_rd_digit
);

   // Bit order of the serial bundle: {load, data, clk}
   logic [2:0] w_line_raw;
   logic [2:0] w_line_pre;
   assign w_line_raw = {i_max7219_load, i_max7219_data, i_max7219_clk};

   generate
      if (G_SYNC != 0) begin : g_sync
         logic [2:0] meta_q;
         logic [2:0] sync_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_q <= '1;
               sync_q <= '1;
            end else begin
               meta_q <= w_line_raw;
               sync_q <= meta_q;
            end
         end
         assign w_line_pre = sync_q;
      end else begin : g_nosync
         assign w_line_pre = w_line_raw;
      end
   endgenerate

   logic [2:0]  s1_q;
   logic [1:0]  s2_q;          // {load, clk} previous sample
   logic [15:0] sr_q,    sr_d;
   logic [4:0]  cnt_q,   cnt_d;
   logic [4:0]  cnt_sh;
   logic        dout_q,  dout_d;
   logic        valid_q, valid_d;
   logic        err_q,   err_d;
   logic [15:0] data_q,  data_d;
   logic [15:0] fcnt_q,  fcnt_d;
   logic [7:0]  decode_q, decode_d;
   logic [3:0]  inten_q, inten_d;
   logic [2:0]  scan_q,  scan_d;
   logic        shdn_q,  shdn_d;
   logic        dtest_q, dtest_d;
   logic [7:0]  digit_q [8];
   logic [7:0]  digit_d [8];
   logic [7:0]  rd_q,    rd_d;

   logic w_clk_rise, w_clk_fall, w_load_rise, w_din;
   assign w_clk_rise  =  s1_q[0] & ~s2_q[0];
   assign w_clk_fall  = ~s1_q[0] &  s2_q[0];
   assign w_load_rise =  s1_q[2] & ~s2_q[1];
   assign w_din       =  s1_q[1];

   always_comb begin
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      cnt_sh   = cnt_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      data_d   = data_q;
      fcnt_d   = fcnt_q;
      decode_d = decode_q;
      inten_d  = inten_q;
      scan_d   = scan_q;
      shdn_d   = shdn_q;
      dtest_d  = dtest_q;
      digit_d  = digit_q;
      rd_d     = digit_q[i_rd_addr];

      if (w_clk_rise) begin
         sr_d = {sr_q[14:0], w_din};
         if (cnt_q != 5'd31) cnt_sh = cnt_q + 5'd1;
      end
      cnt_d = cnt_sh;
      if (w_clk_fall) dout_d = sr_q[15];

      // A shift in the same cycle as LOAD rising is part of the latched word
      if (w_load_rise) begin
         data_d = sr_d;
         cnt_d  = '0;
         if (cnt_sh[4]) begin
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            case (sr_d[11:8])
               4'h1, 4'h2, 4'h3, 4'h4,
               4'h5, 4'h6, 4'h7, 4'h8: digit_d[3'(sr_d[11:8] - 4'd1)] = sr_d[7:0];
               4'h9: decode_d = sr_d[7:0];
               4'hA: inten_d  = sr_d[3:0];
               4'hB: scan_d   = sr_d[2:0];
               4'hC: shdn_d   = sr_d[0];
               4'hF: dtest_d  = sr_d[0];
               default: ;
            endcase
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '1;
         s2_q     <= '1;
         sr_q     <= '0;
         cnt_q    <= '0;
         dout_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         data_q   <= '0;
         fcnt_q   <= '0;
         decode_q <= '0;
         inten_q  <= '0;
         scan_q   <= '0;
         shdn_q   <= 1'b0;
         dtest_q  <= 1'b0;
         digit_q  <= '{default: '0};
         rd_q     <= '0;
      end else begin
         s1_q     <= w_line_pre;
         s2_q     <= {s1_q[2], s1_q[0]};
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         data_q   <= data_d;
         fcnt_q   <= fcnt_d;
         decode_q <= decode_d;
         inten_q  <= inten_d;
         scan_q   <= scan_d;
         shdn_q   <= shdn_d;
         dtest_q  <= dtest_d;
         digit_q  <= digit_d;
         rd_q     <= rd_d;
      end
   end

   assign o_max7219_dout = dout_q;
   assign o_frame_valid  = valid_q;
   assign o_frame_err    = err_q;
   assign o_frame_data   = data_q;
   assign o_frame_cnt    = fcnt_q;
   assign o_decode_mode  = decode_q;
   assign o_intensity    = inten_q;
   assign o_scan_limit   = scan_q;
   assign o_shutdown_n   = shdn_q;
   assign o_display_test = dtest_q;
   assign o_rd_digit     = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_rx_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_max7219_rx_model : scoreboard bench, G_SYNC=0 and G_SYNC=1 instances side by side
// Rev 1.0
// ============================================================================
module tb_max7219_rx_model;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld  = 1'b0;
   logic       din = 1'b0;
   logic       sck = 1'b0;
   logic [2:0] rd_addr = 3'd0;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        fv0, fe0, dout0, sd0, dt0, fv1, fe1, dout1, sd1, dt1;
   logic [15:0] fd0, fc0, fd1, fc1;
   logic [7:0]  dm0, rd0, dm1, rd1;
   logic [3:0]  in0, in1;
   logic [2:0]  sl0, sl1;

   max7219_rx_model #(.G_SYNC(0)) dut0 (
      .clk(clk), .rst(rst), .i_max7219_load(ld), .i_max7219_data(din), .i_max7219_clk(sck),
      .o_max7219_dout(dout0), .o_frame_valid(fv0), .o_frame_err(fe0), .o_frame_data(fd0),
      .o_frame_cnt(fc0), .o_decode_mode(dm0), .o_intensity(in0), .o_scan_limit(sl0),
      .o_shutdown_n(sd0), .o_display_test(dt0), .i_rd_addr(rd_addr), .o_rd_digit(rd0));

   max7219_rx_model #(.G_SYNC(1)) dut1 (
      .clk(clk), .rst(rst), .i_max7219_load(ld), .i_max7219_data(din), .i_max7219_clk(sck),
      .o_max7219_dout(dout1), .o_frame_valid(fv1), .o_frame_err(fe1), .o_frame_data(fd1),
      .o_frame_cnt(fc1), .o_decode_mode(dm1), .o_intensity(in1), .o_scan_limit(sl1),
      .o_shutdown_n(sd1), .o_display_test(dt1), .i_rd_addr(rd_addr), .o_rd_digit(rd1));

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [15:0] data;
      bit          ok;
      logic [15:0] cnt;
      int unsigned raise;
   } frame_t;

   frame_t q0[$];
   frame_t q1[$];

   // Reference model of the device state
   logic [15:0] m_sr;
   int          m_bits;
   logic [15:0] m_fcnt;
   logic [7:0]  m_digit [8];
   logic [7:0]  m_decode;
   logic [3:0]  m_int;
   logic [2:0]  m_scan;
   logic        m_shdn;
   logic        m_dtest;

   task automatic m_reset();
      m_sr = '0; m_bits = 0; m_fcnt = '0;
      for (int i = 0; i < 8; i++) m_digit[i] = '0;
      m_decode = '0; m_int = '0; m_scan = '0; m_shdn = 1'b0; m_dtest = 1'b0;
      q0.delete(); q1.delete();
   endtask

   task automatic m_apply(input logic [15:0] w);
      logic [2:0] idx;
      idx = 3'(w[11:8] - 4'd1);
      case (w[11:8])
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: m_digit[idx] = w[7:0];
         4'h9: m_decode = w[7:0];
         4'hA: m_int    = w[3:0];
         4'hB: m_scan   = w[2:0];
         4'hC: m_shdn   = w[0];
         4'hF: m_dtest  = w[0];
         default: ;
      endcase
   endtask

   task automatic handle(input int id, input logic v, input logic e,
                         input logic [15:0] fd, input logic [15:0] fc);
      frame_t f;
      int     qlen;
      qlen = (id == 0) ? q0.size() : q1.size();
      chk($sformatf("pending%0d", id), qlen != 0, 1'b1);
      if (qlen != 0) begin
         f = (id == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("fv%0d", id), v, f.ok);
         chk($sformatf("fe%0d", id), e, !f.ok);
         chk($sformatf("fd%0d", id), fd, f.data);
         chk($sformatf("fc%0d", id), fc, f.cnt);
         chk($sformatf("lat%0d", id), cyc - f.raise, (id == 0) ? 2 : 4);
      end
   endtask

   always @(negedge clk) if (!rst && (fv0 || fe0)) handle(0, fv0, fe0, fd0, fc0);
   always @(negedge clk) if (!rst && (fv1 || fe1)) handle(1, fv1, fe1, fd1, fc1);

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         din = v[i];
         wait_cyc(4);
         sck = 1'b1;
         m_sr = {m_sr[14:0], v[i]};
         if (m_bits < 31) m_bits++;
         wait_cyc(4);
         sck = 1'b0;
         wait_cyc(5);
         chk("dout0", dout0, m_sr[15]);
         chk("dout1", dout1, m_sr[15]);
      end
   endtask

   task automatic do_load(input bit chk_rd);
      frame_t     f;
      logic [7:0] old;
      bit         seen;
      old = m_digit[rd_addr];
      ld = 1'b1;
      f.data = m_sr;
      f.ok   = (m_bits >= 16);
      if (f.ok) begin
         m_fcnt = m_fcnt + 16'd1;
         m_apply(m_sr);
      end
      f.cnt   = m_fcnt;
      f.raise = cyc;
      q0.push_back(f);
      q1.push_back(f);
      m_bits = 0;
      if (chk_rd) begin
         seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fv0) seen = 1'b1;
         end
         chk("rd_seen", seen, 1'b1);
         chk("rd_old", rd0, old);
         @(negedge clk);
         chk("rd_new", rd0, m_digit[rd_addr]);
      end
      wait_cyc(8);
      ld = 1'b0;
      wait_cyc(4);
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".dm0"}, dm0, m_decode);  chk({tag, ".dm1"}, dm1, m_decode);
      chk({tag, ".in0"}, in0, m_int);     chk({tag, ".in1"}, in1, m_int);
      chk({tag, ".sl0"}, sl0, m_scan);    chk({tag, ".sl1"}, sl1, m_scan);
      chk({tag, ".sd0"}, sd0, m_shdn);    chk({tag, ".sd1"}, sd1, m_shdn);
      chk({tag, ".dt0"}, dt0, m_dtest);   chk({tag, ".dt1"}, dt1, m_dtest);
      chk({tag, ".fc0"}, fc0, m_fcnt);    chk({tag, ".fc1"}, fc1, m_fcnt);
      chk({tag, ".rd0"}, rd0, m_digit[rd_addr]);
      chk({tag, ".rd1"}, rd1, m_digit[rd_addr]);
   endtask

   initial begin
      m_reset();
      rst = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(20);
      check_regs("idle");
      chk("idle.fd0", fd0, 16'h0000);  chk("idle.fd1", fd1, 16'h0000);
      chk("idle.pulse0", {fv0, fe0}, 2'b00);
      chk("idle.pulse1", {fv1, fe1}, 2'b00);
      chk("idle.dout0", dout0, 1'b0);  chk("idle.dout1", dout1, 1'b0);

      send(32'h0C01, 16);
      do_load(1'b0);
      check_regs("shdn");
      chk("shdn.fd0", fd0, 16'h0C01);
      chk("shdn.on", sd0, 1'b1);

      rd_addr = 3'd2;
      send(32'h0A3F, 16); do_load(1'b0);
      send(32'h0B07, 16); do_load(1'b0);
      send(32'h0355, 16); do_load(1'b1);
      check_regs("digit2");
      chk("int.F", in1, 4'hF);

      send(32'h02A5, 10); do_load(1'b0);
      check_regs("err10");
      send(32'h0F01, 16); do_load(1'b0);
      check_regs("dtest");
      send(32'h7FFF, 15); do_load(1'b0);
      check_regs("err15");

      rd_addr = 3'd0;
      send(32'h01AA_0102, 32); do_load(1'b0);
      check_regs("long");
      chk("long.fd1", fd1, 16'h0102);

      send(32'h00A5, 8);
      rst = 1'b1;
      wait_cyc(2);
      m_reset();
      rst = 1'b0;
      wait_cyc(4);
      check_regs("rst");
      send(32'h0901, 16); do_load(1'b0);
      check_regs("decode");
      chk("decode.dm0", dm0, 8'h01);

      wait_cyc(10);
      chk("drain0", q0.size(), 0);
      chk("drain1", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
